// File: rtl/ascensor_pkg.sv
// ascensor_pkg: types shared by the elevator controllers.
//   estado_t   - externally visible motion state (also imported by the door controller)
//   fsm_t      - internal states of the motor FSM
//   N_PISOS_DEF- default number of floors
//   estado_de  - maps an FSM state to the motion state it shows on the outputs
package ascensor_pkg;

    localparam int N_PISOS_DEF = 8;

    typedef enum logic [1:0] {
        DETENIDO = 2'b00,
        SUBIENDO = 2'b01,
        BAJANDO  = 2'b10
    } estado_t;

    typedef enum logic [2:0] {
        ST_REPOSO,
        ST_SUBIENDO,
        ST_BAJANDO,
        ST_PARADA,
        ST_ESPERA
    } fsm_t;

    function automatic estado_t estado_de(fsm_t s);
        case (s)
            ST_SUBIENDO: return SUBIENDO;
            ST_BAJANDO:  return BAJANDO;
            default:     return DETENIDO;
        endcase
    endfunction

endpackage

// File: rtl/buscador_pedidos.sv
// buscador_pedidos: combinational request finder.
//   pendientes - latched outstanding requests, bit i = floor i
//   pisos      - current floor, binary
//   hay_arriba - some request strictly above pisos
//   hay_abajo  - some request strictly below pisos
//   hay_aqui   - request at pisos
module buscador_pedidos
    import ascensor_pkg::*;
#(
    parameter int N_PISOS = N_PISOS_DEF,
    localparam int PW = (N_PISOS > 1) ? $clog2(N_PISOS) : 1
) (
    input  logic [N_PISOS-1:0] pendientes,
    input  logic [PW-1:0]      pisos,
    output logic               hay_arriba,
    output logic               hay_abajo,
    output logic               hay_aqui
);

    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        hay_aqui   = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (PW'(i) > pisos)
                hay_arriba = hay_arriba | pendientes[i];
            else if (PW'(i) < pisos)
                hay_abajo = hay_abajo | pendientes[i];
            else
                hay_aqui = pendientes[i];
        end
    end

endmodule

// File: rtl/control_motor.sv
// control_motor: elevator car-motion controller with collective (SCAN) scheduling.
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   botones    - request strobes, bit i = floor i, sampled every cycle
//   trabajando - door controller busy; holds the car while high
//   pisos      - current floor (registered)
//   estado     - DETENIDO / SUBIENDO / BAJANDO (registered)
//   llegada    - one-cycle pulse when the car stops at a requested floor
//   pendientes - latched outstanding requests
module control_motor
    import ascensor_pkg::*;
#(
    parameter int N_PISOS = N_PISOS_DEF,
    parameter int T_VIAJE = 16,
    parameter int T_ACK   = 8,
    localparam int PW = (N_PISOS > 1) ? $clog2(N_PISOS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PISOS-1:0] botones,
    input  logic               trabajando,
    output logic [PW-1:0]      pisos,
    output estado_t            estado,
    output logic               llegada,
    output logic [N_PISOS-1:0] pendientes
);

    localparam int CW = (T_VIAJE > 1) ? $clog2(T_VIAJE) : 1;
    localparam int AW = (T_ACK > 1) ? $clog2(T_ACK) : 1;

    fsm_t               state, state_d;
    logic [PW-1:0]      pisos_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [AW-1:0]      ack_cnt, ack_cnt_d;
    logic               dir_up, dir_up_d;
    logic               paso, paso_d;     // a floor step happened on the previous edge
    logic               vio, vio_d;       // trabajando has risen during ESPERA
    logic [N_PISOS-1:0] pend_d;
    logic               hay_arriba, hay_abajo, hay_aqui;
    logic               ir_arriba, ir_abajo, subiendo, adelante, absorbe;

    buscador_pedidos #(.N_PISOS(N_PISOS)) u_buscador (
        .pendientes (pendientes),
        .pisos      (pisos),
        .hay_arriba (hay_arriba),
        .hay_abajo  (hay_abajo),
        .hay_aqui   (hay_aqui)
    );

    // Remembered direction wins; the opposite one is taken only when nothing lies ahead.
    assign ir_arriba = dir_up ? hay_arriba : (hay_arriba && !hay_abajo);
    assign ir_abajo  = dir_up ? (hay_abajo && !hay_arriba) : hay_abajo;
    assign subiendo  = (state == ST_SUBIENDO);
    assign adelante  = subiendo ? hay_arriba : hay_abajo;

    always_comb begin
        state_d   = state;
        pisos_d   = pisos;
        cnt_d     = cnt;
        ack_cnt_d = ack_cnt;
        dir_up_d  = dir_up;
        paso_d    = paso;
        vio_d     = vio;
        case (state)
            ST_REPOSO: begin
                if (!trabajando) begin
                    if (hay_aqui) begin
                        state_d = ST_PARADA;
                    end else if (ir_arriba || ir_abajo) begin
                        state_d  = ir_arriba ? ST_SUBIENDO : ST_BAJANDO;
                        dir_up_d = ir_arriba;
                        cnt_d    = '0;
                        paso_d   = 1'b0;
                    end
                end
            end
            ST_SUBIENDO, ST_BAJANDO: begin
                // Stop/continue is decided in the cycle after the step, once the
                // finder sees the new floor.
                if (paso && hay_aqui) begin
                    state_d = ST_PARADA;
                end else if (paso && !adelante) begin
                    state_d = ST_REPOSO;
                end else if (cnt == CW'(T_VIAJE - 1)) begin
                    cnt_d   = '0;
                    paso_d  = 1'b1;
                    pisos_d = subiendo ? pisos + PW'(1) : pisos - PW'(1);
                end else begin
                    cnt_d  = cnt + CW'(1);
                    paso_d = 1'b0;
                end
            end
            ST_PARADA: begin
                state_d   = ST_ESPERA;
                ack_cnt_d = '0;
                vio_d     = 1'b0;
            end
            ST_ESPERA: begin
                if (!vio) begin
                    if (trabajando)
                        vio_d = 1'b1;
                    else if (ack_cnt == AW'(T_ACK - 1))
                        state_d = ST_REPOSO;
                    else
                        ack_cnt_d = ack_cnt + AW'(1);
                end else if (!trabajando) begin
                    state_d = ST_REPOSO;
                end
            end
            default: state_d = ST_REPOSO;
        endcase

        // The served floor's bit is cleared entering PARADA and stays absorbed
        // until the doors are done.
        absorbe = (state_d == ST_PARADA) || (state == ST_PARADA) || (state == ST_ESPERA);
        pend_d  = pendientes | botones;
        if (absorbe) begin
            for (int i = 0; i < N_PISOS; i++) begin
                if (PW'(i) == pisos_d)
                    pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REPOSO;
            pisos      <= '0;
            cnt        <= '0;
            ack_cnt    <= '0;
            dir_up     <= 1'b1;
            paso       <= 1'b0;
            vio        <= 1'b0;
            pendientes <= '0;
            estado     <= DETENIDO;
            llegada    <= 1'b0;
        end else begin
            state      <= state_d;
            pisos      <= pisos_d;
            cnt        <= cnt_d;
            ack_cnt    <= ack_cnt_d;
            dir_up     <= dir_up_d;
            paso       <= paso_d;
            vio        <= vio_d;
            pendientes <= pend_d;
            estado     <= estado_de(state_d);
            llegada    <= (state_d == ST_PARADA);
        end
    end

endmodule

// File: tb/tb_control_motor.sv
// tb_control_motor: directed + randomized bench for control_motor.
// The reference is trip-level: travel latency = T_VIAJE * distance + 1,
// door waits by handshake rules, and SCAN visiting order from sorted request lists.
module tb_control_motor;
    import ascensor_pkg::*;

    localparam int NP = 8;
    localparam int TV = 16;
    localparam int TA = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          trabajando = 1'b0;
    logic [NP-1:0] botones = '0;
    logic [2:0]    pisos;
    logic [1:0]    estado;
    logic          llegada;
    logic [NP-1:0] pendientes;

    int            n_cmp = 0;
    int            n_err = 0;
    int            pos;
    logic          m_up;
    logic [NP-1:0] pend_m;

    control_motor #(.N_PISOS(NP), .T_VIAJE(TV), .T_ACK(TA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .botones    (botones),
        .trabajando (trabajando),
        .pisos      (pisos),
        .estado     (estado),
        .llegada    (llegada),
        .pendientes (pendientes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("estado_no_11", 32'(estado != 2'b11), 32'd1);
    endtask

    function automatic logic [1:0] dir_de(input int from, input int to);
        return (to > from) ? 2'b01 : 2'b10;
    endfunction

    // Strobe a set of floors for one cycle from idle.
    task automatic pedir(input logic [NP-1:0] mask);
        botones = mask;
        tick();
        botones = '0;
        pend_m = pend_m | mask;
        check("pend_latch", pendientes, pend_m);
    endtask

    // From idle: request, then expect departure toward the first stop.
    task automatic salir(input logic [NP-1:0] mask, input int first);
        pedir(mask);
        tick();
        check("salida_estado", estado, dir_de(pos, first));
        m_up = (first > pos);
    endtask

    // From the departure cycle: travel to dest with no intermediate stop.
    task automatic mover(input int dest, input int extra, input int extra_at);
        int d, sgn, lat;
        d   = (dest > pos) ? dest - pos : pos - dest;
        sgn = (dest > pos) ? 1 : -1;
        lat = TV * d + 1;
        for (int t = 1; t <= lat; t++) begin
            if (extra >= 0 && t == extra_at) botones = NP'(1) << extra;
            tick();
            if (extra >= 0 && t == extra_at) begin
                botones = '0;
                pend_m[extra] = 1'b1;
            end
            if (t % TV == 0) check("pisos_paso", pisos, pos + sgn * (t / TV));
            if (t < lat) check("sin_llegada", llegada, 0);
        end
        check("llegada", llegada, 1);
        check("pisos_llegada", pisos, dest);
        check("estado_llegada", estado, 0);
        pend_m[dest] = 1'b0;
        check("pend_llegada", pendientes, pend_m);
        pos = dest;
    endtask

    // Called in the llegada cycle: door phase, optional new request, then
    // the expected estado once REPOSO has re-evaluated.
    task automatic puerta(input int press, input int hold, input logic [1:0] exp_est);
        if (press >= 0) botones = NP'(1) << press;
        if (hold > 0) trabajando = 1'b1;
        tick();
        botones = '0;
        if (press >= 0) pend_m[press] = 1'b1;
        check("llegada_un_ciclo", llegada, 0);
        check("pend_puerta", pendientes, pend_m);
        if (hold > 0) begin
            for (int t = 2; t <= hold; t++) begin
                tick();
                check("retenido_puerta", estado, 0);
            end
            trabajando = 1'b0;
            tick();
            check("reposo_tras_puerta", estado, 0);
        end else begin
            for (int t = 2; t <= TA + 1; t++) begin
                tick();
                check("espera_ack", estado, 0);
            end
        end
        tick();
        check("salida_tras_puerta", estado, exp_est);
        if (exp_est != 2'b00) m_up = (exp_est == 2'b01);
    endtask

    initial begin
        int            nxt, hold;
        logic [NP-1:0] mask;
        int            ups[$], dns[$], ord[$];

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_pisos", pisos, 0);
        check("rst_estado", estado, 0);
        check("rst_llegada", llegada, 0);
        check("rst_pend", pendientes, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pos = 0; m_up = 1'b1; pend_m = '0;

        // Current-floor request at floor 0, bit held through ESPERA
        botones = NP'(1);
        tick();
        check("aqui_pend", pendientes, 1);
        check("aqui_sin_llegada", llegada, 0);
        tick();
        check("aqui_llegada", llegada, 1);
        check("aqui_pend_borrado", pendientes, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("absorbido", pendientes, 0);
            check("absorbido_llegada", llegada, 0);
        end
        botones = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("aqui_reposo", estado, 0);
            check("aqui_pend_final", pendientes, 0);
        end

        // Single request to floor 3, door busy 20 cycles
        salir(8'b0000_1000, 3);
        mover(3, -1, 0);
        puerta(-1, 20, 2'b00);

        // SCAN: going up past floor 4 toward 6, floor 1 requested on the way
        salir(NP'(1) << 6, 6);
        mover(6, 1, TV + 5);
        puerta(-1, 0, 2'b10);
        mover(1, -1, 0);

        // Top boundary: only request above while remembered direction is down
        puerta(7, 0, 2'b01);
        mover(7, -1, 0);
        puerta(-1, 0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tope_pisos", pisos, 7);
            check("tope_estado", estado, 0);
        end

        // Hold in REPOSO while trabajando is high
        trabajando = 1'b1;
        pedir(NP'(1) << 2);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hold_estado", estado, 0);
            check("hold_pisos", pisos, 7);
        end
        trabajando = 1'b0;
        tick();
        check("hold_salida", estado, 2'b10);
        m_up = 1'b0;
        mover(2, -1, 0);

        // Random single trips with random door behaviour
        for (int i = 0; i < 8; i++) begin
            nxt = $urandom_range(0, NP - 1);
            if (nxt == pos) nxt = (pos + 1 + $urandom_range(0, NP - 2)) % NP;
            hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 20);
            puerta(nxt, hold, dir_de(pos, nxt));
            mover(nxt, -1, 0);
        end
        puerta(-1, 0, 2'b00);

        // Random multi-request batches served in SCAN order
        for (int r = 0; r < 3; r++) begin
            mask = NP'($urandom);
            mask[pos] = 1'b0;
            if (mask == '0) mask[(pos + 3) % NP] = 1'b1;
            ups.delete(); dns.delete(); ord.delete();
            for (int f = pos + 1; f < NP; f++) if (mask[f]) ups.push_back(f);
            for (int f = pos - 1; f >= 0; f--) if (mask[f]) dns.push_back(f);
            if (m_up || ups.size() == 0) begin
                if (m_up) begin
                    foreach (ups[k]) ord.push_back(ups[k]);
                    foreach (dns[k]) ord.push_back(dns[k]);
                end else begin
                    foreach (dns[k]) ord.push_back(dns[k]);
                    foreach (ups[k]) ord.push_back(ups[k]);
                end
            end else begin
                if (dns.size() > 0) foreach (dns[k]) ord.push_back(dns[k]);
                foreach (ups[k]) ord.push_back(ups[k]);
            end
            salir(mask, ord[0]);
            mover(ord[0], -1, 0);
            for (int k = 1; k < ord.size(); k++) begin
                puerta(-1, 0, dir_de(pos, ord[k]));
                mover(ord[k], -1, 0);
            end
            puerta(-1, 0, 2'b00);
        end

        // Reset while travelling up between floors
        if (pos >= 6) begin
            salir(NP'(1), 0);
            mover(0, -1, 0);
            puerta(-1, 0, 2'b00);
        end
        salir(NP'(1) << 7, 7);
        for (int i = 0; i < TV + 5; i++) tick();
        check("mid_estado", estado, 2'b01);
        rst_n = 1'b0;
        #2;
        check("mid_rst_pisos", pisos, 0);
        check("mid_rst_estado", estado, 0);
        check("mid_rst_llegada", llegada, 0);
        check("mid_rst_pend", pendientes, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_sin_llegada", llegada, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_estado", estado, 0);
            check("post_rst_pisos", pisos, 0);
            check("post_rst_llegada", llegada, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_motor.md
# control_motor

Car-motion controller for the elevator, directly upstream of the door controller. It latches hall/car floor requests, runs a collective (SCAN) scheduler, and simulates travel with a per-floor cycle counter. It drives current floor (`pisos`) and motion state (`estado`), and issues a one-cycle `llegada` pulse to the door controller on each service stop. It holds the car while the door controller reports `trabajando`.

## Interface
- `N_PISOS`, 8: number of floors, ≥2.
- `T_VIAJE`, 16: cycles to travel one floor, ≥2.
- `T_ACK`, 8: max cycles to wait for `trabajando` to rise after `llegada`, ≥1.

Ports (`PW = $clog2(N_PISOS)`):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `botones`  in  N_PISOS  request strobes, bit i = floor i; level-sampled each cycle.
- `trabajando`  in  1  door controller busy (doors open, closing, or obstructed).
- `pisos`  out  PW  current floor, binary.
- `estado`  out  2  00 DETENIDO, 01 SUBIENDO, 10 BAJANDO; 11 never driven.
- `llegada`  out  1  one-cycle pulse: car stopped at a requested floor.
- `pendientes`  out  N_PISOS  latched outstanding requests.

## Operation
- **Reset values:** `pisos=0`, `estado=DETENIDO`, `llegada=0`, `pendientes=0`, direction memory = up, travel counter = 0.
- **Request latching:** `pendientes |= botones` each cycle. The bit for the floor being served is cleared on the `llegada` cycle. A `botones` bit for that floor in the same cycle is absorbed, not latched.
- **FSM states:** REPOSO, SUBIENDO, BAJANDO, PARADA, ESPERA_PUERTAS.
- **REPOSO:** `estado=DETENIDO`. Leave REPOSO only when `trabajando=0`. Exits are checked in this order:
  - Request at `pisos`: go to PARADA.
  - Requests ahead in the remembered direction: move in that direction.
  - Requests only in the opposite direction: move in the opposite direction.
  - Otherwise stay in REPOSO.
- **SUBIENDO / BAJANDO:** the counter runs 0..T_VIAJE-1. At terminal count, `pisos` steps ±1 and the counter clears. If the new floor is pending, go to PARADA. Otherwise keep moving, provided requests remain ahead. If none remain ahead, go to REPOSO; it re-evaluates next cycle.
- **PARADA:** a single cycle. `llegada=1`, the pending bit for `pisos` is cleared, `estado=DETENIDO`. Then go to ESPERA_PUERTAS.
- **ESPERA_PUERTAS:** wait for `trabajando` to rise, then fall, then go to REPOSO. If `trabajando` does not rise within T_ACK cycles, go to REPOSO.
- **Direction memory:** updated on every departure from REPOSO.
- **Boundaries:**
  - The car never steps below floor 0 or above floor N_PISOS-1. Reaching either end with nothing ahead yields REPOSO.
  - Requests at the current floor while in ESPERA_PUERTAS are absorbed; the bit is not set.
- **Reset mid-travel:** the car returns to floor 0 and DETENIDO immediately. No `llegada` is issued.

## Timing
- All outputs are registered. `llegada` is high for exactly one cycle.
- Request at the current floor in REPOSO with `trabajando=0`, strobe at cycle k:
  - cycle k+1: REPOSO sees the latched bit.
  - cycle k+2: `llegada=1`.
- Departure: `estado` changes on the edge that leaves REPOSO. One floor takes T_VIAJE cycles from departure until `pisos` updates.
- Stop: `llegada` asserts on the cycle after `pisos` updates to a pending floor.
- `trabajando=1` in REPOSO holds the car indefinitely. No departure occurs while it is high.

## Structure
- Shared package `ascensor_pkg` holds:
  - `estado_t` enum (DETENIDO=2'b00, SUBIENDO=2'b01, BAJANDO=2'b10);
  - the FSM state enum;
  - the `N_PISOS` default.
- The door controller imports the same `estado_t`.
- One sub-module, `buscador_pedidos`: combinational. Given `pendientes` and `pisos`, it produces `hay_arriba`, `hay_abajo`, and `hay_aqui`.
- Counter, FSM and request register live in `control_motor`.

## Test plan
- **Reset, then single request.** Pulse `botones=8'b0000_1000`. Expect `estado=SUBIENDO`, `pisos` 1→2→3 every 16 cycles, then `llegada` for one cycle at floor 3 and `pendientes=0`.
- **Door handshake.** After `llegada`, raise `trabajando` for 20 cycles. The car stays DETENIDO until 1 cycle after it drops. Separately, with no `trabajando` response, REPOSO follows T_ACK=8 cycles later.
- **SCAN order.** Car at floor 4 moving up, requests at floors 6 and 1. Expect stop at 6, then reverse, then stop at 1. No stop at 4.
- **Current-floor and absorbed requests.** `botones` bit 0 set at floor 0 in REPOSO gives `llegada` 2 cycles later. The same bit held during ESPERA_PUERTAS leaves `pendientes[0]=0`.
- **Boundary and hold.** Request floor 7, arrive, no further requests: expect REPOSO at 7, with `estado` never 11. Holding `trabajando=1` with pending floor 2 gives no movement.
- **Reset mid-travel.** Assert `rst_n=0` while SUBIENDO between floors. Outputs reach reset values asynchronously, with no `llegada` pulse.
